// File: rtl/sensor_poll_scheduler.sv
`timescale 1ns/1ps
// Measurement-cycle sequencer for the cold-storage node: paces DHT11 reads with timeout/retry,
// latches the last good sample, then strobes the LCD refresh and the UART telemetry transmit.
module sensor_poll_scheduler #(
  parameter int POLL_PERIOD_CYC = 2000000,
  parameter int DHT_TIMEOUT_CYC = 50000,
  parameter int RETRY_GAP_CYC   = 1000000,
  parameter int MAX_RETRY       = 3,
  parameter int LCD_PULSE_CYC   = 4,
  parameter int TX_TIMEOUT_CYC  = 200000,
  parameter int DATA_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              poll_now,
  input  logic              dht_data_ready,
  input  logic [DATA_W-1:0] temperature_in,
  input  logic [DATA_W-1:0] humidity_in,
  input  logic              tx_msg_done,
  output logic              dht_en,
  output logic [DATA_W-1:0] temperature,
  output logic [DATA_W-1:0] humidity,
  output logic              data_valid,
  output logic              sensor_fault,
  output logic              lcd_en,
  output logic              en_tx,
  output logic              tx_err,
  output logic              busy
);

  localparam int MAX_AB   = (POLL_PERIOD_CYC > DHT_TIMEOUT_CYC) ? POLL_PERIOD_CYC : DHT_TIMEOUT_CYC;
  localparam int MAX_ABC  = (MAX_AB > RETRY_GAP_CYC) ? MAX_AB : RETRY_GAP_CYC;
  localparam int MAX_ABCD = (MAX_ABC > LCD_PULSE_CYC) ? MAX_ABC : LCD_PULSE_CYC;
  localparam int MAX_CYC  = (MAX_ABCD > TX_TIMEOUT_CYC) ? MAX_ABCD : TX_TIMEOUT_CYC;
  localparam int CNT_W    = $clog2(MAX_CYC) + 1;
  localparam int RTY_W    = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_GAP,
    S_LATCH,
    S_LCD,
    S_TX
  } state_t;

  // The counter holds the cycles remaining after the current one, so a phase of
  // N cycles is loaded with N-1 and ends in the cycle the counter reads zero.
  function automatic logic [CNT_W-1:0] span(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next, cnt_dec;
  logic [RTY_W-1:0]  retry, retry_next, retry_inc;
  logic              pending, pending_next;
  logic [DATA_W-1:0] temp_next, hum_next;
  logic              valid_next, fault_next, tx_err_next;
  logic              cnt_zero;

  assign cnt_zero  = (cnt == '0);
  assign cnt_dec   = cnt - CNT_W'(1);
  assign retry_inc = retry + RTY_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= span(POLL_PERIOD_CYC);
      retry        <= '0;
      pending      <= 1'b0;
      temperature  <= '0;
      humidity     <= '0;
      data_valid   <= 1'b0;
      sensor_fault <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      retry        <= retry_next;
      pending      <= pending_next;
      temperature  <= temp_next;
      humidity     <= hum_next;
      data_valid   <= valid_next;
      sensor_fault <= fault_next;
      tx_err       <= tx_err_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    retry_next   = retry;
    pending_next = pending;
    temp_next    = temperature;
    hum_next     = humidity;
    valid_next   = data_valid;
    fault_next   = sensor_fault;
    tx_err_next  = 1'b0;

    // Requests that arrive mid-cycle coalesce into one poll taken on return to IDLE.
    if (poll_now && (state != S_IDLE)) pending_next = 1'b1;

    case (state)
      S_IDLE: begin
        if (cnt_zero || pending || poll_now) begin
          state_next   = S_READ;
          cnt_next     = span(DHT_TIMEOUT_CYC);
          retry_next   = '0;
          pending_next = 1'b0;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      S_READ: begin
        // A frame arriving in the final window cycle still counts as a success.
        if (dht_data_ready) begin
          state_next = S_LATCH;
          temp_next  = temperature_in;
          hum_next   = humidity_in;
          valid_next = 1'b1;
          fault_next = 1'b0;
        end else if (cnt_zero) begin
          retry_next = retry_inc;
          if (retry_inc < RTY_W'(MAX_RETRY)) begin
            state_next = S_GAP;
            cnt_next   = span(RETRY_GAP_CYC);
          end else begin
            state_next = S_IDLE;
            cnt_next   = span(POLL_PERIOD_CYC);
            fault_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_dec;
        end
      end

      S_GAP: begin
        if (cnt_zero) begin
          state_next = S_READ;
          cnt_next   = span(DHT_TIMEOUT_CYC);
        end else begin
          cnt_next = cnt_dec;
        end
      end

      S_LATCH: begin
        state_next = S_LCD;
        cnt_next   = span(LCD_PULSE_CYC);
      end

      S_LCD: begin
        if (cnt_zero) begin
          state_next = S_TX;
          cnt_next   = span(TX_TIMEOUT_CYC);
        end else begin
          cnt_next = cnt_dec;
        end
      end

      S_TX: begin
        if (tx_msg_done) begin
          state_next = S_IDLE;
          cnt_next   = span(POLL_PERIOD_CYC);
        end else if (cnt_zero) begin
          state_next  = S_IDLE;
          cnt_next    = span(POLL_PERIOD_CYC);
          tx_err_next = 1'b1;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = span(POLL_PERIOD_CYC);
      end
    endcase
  end

  // Strobes decode straight from the state register so reset clears them without a clock.
  assign dht_en = (state == S_READ);
  assign lcd_en = (state == S_LCD);
  assign en_tx  = (state == S_TX);
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
`timescale 1ns/1ps
// Randomized bench for sensor_poll_scheduler: builds an expected per-cycle timeline from
// phase lengths (idle, read windows, gaps, latch, LCD, transmit) and compares every cycle.
module tb_sensor_poll_scheduler;

  localparam int POLL    = 1000;
  localparam int DHT     = 100;
  localparam int GAP     = 50;
  localparam int RETRIES = 3;
  localparam int LCD     = 4;
  localparam int TXTO    = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       poll_now = 1'b0;
  logic       dht_data_ready = 1'b0;
  logic       tx_msg_done = 1'b0;
  logic [7:0] temperature_in = 8'h00;
  logic [7:0] humidity_in = 8'h00;
  logic       dht_en, data_valid, sensor_fault, lcd_en, en_tx, tx_err, busy;
  logic [7:0] temperature, humidity;

  sensor_poll_scheduler #(
    .POLL_PERIOD_CYC(POLL),
    .DHT_TIMEOUT_CYC(DHT),
    .RETRY_GAP_CYC  (GAP),
    .MAX_RETRY      (RETRIES),
    .LCD_PULSE_CYC  (LCD),
    .TX_TIMEOUT_CYC (TXTO),
    .DATA_W         (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .poll_now      (poll_now),
    .dht_data_ready(dht_data_ready),
    .temperature_in(temperature_in),
    .humidity_in   (humidity_in),
    .tx_msg_done   (tx_msg_done),
    .dht_en        (dht_en),
    .temperature   (temperature),
    .humidity      (humidity),
    .data_valid    (data_valid),
    .sensor_fault  (sensor_fault),
    .lcd_en        (lcd_en),
    .en_tx         (en_tx),
    .tx_err        (tx_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef enum int {K_IDLE, K_READ, K_GAP, K_LATCH, K_LCD, K_TX} kind_t;
  typedef struct packed {
    logic busy, dht, lcd, tx, txerr, valid, fault;
    logic [7:0] t;
    logic [7:0] h;
  } obs_t;
  typedef struct packed {
    logic poll, rdy, done;
    logic [7:0] t;
    logic [7:0] h;
  } stim_t;

  obs_t  exp_q[$];
  stim_t stim_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    abort = 1'b0;
  int    poll_rate = 0;

  logic [7:0] m_temp, m_hum;
  logic       m_valid, m_fault, m_pending, m_txerr;
  int         m_retry;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.busy = busy; o.dht = dht_en; o.lcd = lcd_en; o.tx = en_tx; o.txerr = tx_err;
    o.valid = data_valid; o.fault = sensor_fault; o.t = temperature; o.h = humidity;
    return o;
  endfunction

  function automatic logic [7:0] rnd8();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic model_reset();
    m_temp = 8'h00; m_hum = 8'h00; m_valid = 1'b0; m_fault = 1'b0;
    m_pending = 1'b0; m_txerr = 1'b0; m_retry = 0;
  endtask

  // One cycle of timeline: expected outputs for the phase, plus the inputs driven in it.
  task automatic push(input kind_t k, input bit poll, input bit rdy, input bit done,
                      input logic [7:0] t, input logic [7:0] h);
    obs_t e;
    stim_t s;
    e.busy = (k != K_IDLE); e.dht = (k == K_READ); e.lcd = (k == K_LCD); e.tx = (k == K_TX);
    e.txerr = m_txerr; e.valid = m_valid; e.fault = m_fault; e.t = m_temp; e.h = m_hum;
    m_txerr = 1'b0;
    if (k != K_READ && $urandom_range(0, 19) == 0) rdy = 1'b1;
    if (k != K_TX && $urandom_range(0, 19) == 0) done = 1'b1;
    if (k != K_IDLE && poll_rate > 0 && $urandom_range(0, 99) < poll_rate) poll = 1'b1;
    if (poll && k != K_IDLE) m_pending = 1'b1;
    s.poll = poll; s.rdy = rdy; s.done = done; s.t = t; s.h = h;
    exp_q.push_back(e);
    stim_q.push_back(s);
    if (k == K_READ && rdy) begin
      m_temp = t; m_hum = h; m_valid = 1'b1; m_fault = 1'b0;
    end
  endtask

  task automatic idle_wait(input int poll_at);
    m_retry = 0;
    if (m_pending) begin
      push(K_IDLE, 1'b0, 1'b0, 1'b0, rnd8(), rnd8());
      m_pending = 1'b0;
    end else if (poll_at < 0) begin
      repeat (POLL) push(K_IDLE, 1'b0, 1'b0, 1'b0, rnd8(), rnd8());
    end else begin
      repeat (poll_at) push(K_IDLE, 1'b0, 1'b0, 1'b0, rnd8(), rnd8());
      push(K_IDLE, 1'b1, 1'b0, 1'b0, rnd8(), rnd8());
    end
  endtask

  task automatic attempt_fail();
    repeat (DHT) push(K_READ, 1'b0, 1'b0, 1'b0, rnd8(), rnd8());
    m_retry++;
    if (m_retry < RETRIES) repeat (GAP) push(K_GAP, 1'b0, 1'b0, 1'b0, rnd8(), rnd8());
    else m_fault = 1'b1;
  endtask

  task automatic attempt_ok(input int r, input logic [7:0] t, input logic [7:0] h, input int lcd_n);
    repeat (r) push(K_READ, 1'b0, 1'b0, 1'b0, rnd8(), rnd8());
    push(K_READ, 1'b0, 1'b1, 1'b0, t, h);
    push(K_LATCH, 1'b0, 1'b0, 1'b0, rnd8(), rnd8());
    repeat (lcd_n) push(K_LCD, 1'b0, 1'b0, 1'b0, rnd8(), rnd8());
  endtask

  task automatic tx_phase(input int k, input bit timeout, input int pa, input int pb);
    int n;
    n = timeout ? TXTO : k;
    for (int i = 0; i < n; i++)
      push(K_TX, (i == pa) || (i == pb), 1'b0, (!timeout && i == n - 1), rnd8(), rnd8());
    if (timeout) m_txerr = 1'b1;
  endtask

  task automatic run_q();
    obs_t e;
    stim_t s;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      if (!abort) check($sformatf("timeline cycle %0d", cyc), {9'd0, observe()}, {9'd0, e});
      if (n_fail > 40) abort = 1'b1;
      poll_now = s.poll; dht_data_ready = s.rdy; tx_msg_done = s.done;
      temperature_in = s.t; humidity_in = s.h;
      cyc++;
      @(negedge clk);
      #1;
    end
    poll_now = 1'b0; dht_data_ready = 1'b0; tx_msg_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("in_reset", {9'd0, observe()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_release", {9'd0, observe()}, 32'd0);

    // First automatic poll, known sample, transmit acknowledged 30 cycles into TX.
    idle_wait(-1);
    attempt_ok(20, 8'h21, 8'h28, LCD);
    tx_phase(31, 1'b0, -1, -1);
    run_q();

    // Immediate poll, then two requests during TX coalesce into one extra read.
    idle_wait($urandom_range(5, 300));
    attempt_ok($urandom_range(0, DHT - 1), rnd8(), rnd8(), LCD);
    tx_phase($urandom_range(20, 150), 1'b0, 3, 10);
    idle_wait(0);
    attempt_ok($urandom_range(0, DHT - 1), rnd8(), rnd8(), LCD);
    tx_phase($urandom_range(1, 100), 1'b0, -1, -1);
    run_q();

    // Sensor silent: three windows then fault; the next good poll clears it.
    idle_wait(-1);
    attempt_fail(); attempt_fail(); attempt_fail();
    run_q();
    check("fault_set", {31'd0, sensor_fault}, 32'd1);
    idle_wait(-1);
    attempt_ok($urandom_range(0, DHT - 1), rnd8(), rnd8(), LCD);
    tx_phase($urandom_range(1, TXTO), 1'b0, -1, -1);
    run_q();

    // Frame in the final cycle of the third window still latches; done on the last TX cycle.
    idle_wait($urandom_range(0, 200));
    attempt_fail(); attempt_fail();
    attempt_ok(DHT - 1, rnd8(), rnd8(), LCD);
    tx_phase(TXTO, 1'b0, -1, -1);
    run_q();

    // Transmit never acknowledged, then the automatic poll one period later.
    idle_wait($urandom_range(0, 200));
    attempt_ok($urandom_range(0, DHT - 1), rnd8(), rnd8(), LCD);
    tx_phase(0, 1'b1, -1, -1);
    idle_wait(-1);
    attempt_ok($urandom_range(0, DHT - 1), rnd8(), rnd8(), LCD);
    tx_phase($urandom_range(1, TXTO), 1'b0, -1, -1);
    run_q();

    // Random mixes of failures, successes, timeouts and stray poll requests.
    poll_rate = 2;
    for (int it = 0; it < 8; it++) begin
      int nf;
      idle_wait($urandom_range(0, 150));
      nf = $urandom_range(0, RETRIES);
      for (int f = 0; f < nf; f++) attempt_fail();
      if (nf < RETRIES) begin
        attempt_ok($urandom_range(0, DHT - 1), rnd8(), rnd8(), LCD);
        tx_phase($urandom_range(1, TXTO), ($urandom_range(0, 3) == 0), -1, -1);
      end
      run_q();
    end
    poll_rate = 0;

    // Reset while the LCD strobe is high.
    idle_wait($urandom_range(0, 100));
    attempt_ok($urandom_range(0, DHT - 1), rnd8(), rnd8(), 2);
    run_q();
    check("lcd_before_reset", {31'd0, lcd_en}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_lcd_en", {31'd0, lcd_en}, 32'd0);
    check("async_dht_en", {31'd0, dht_en}, 32'd0);
    check("async_en_tx", {31'd0, en_tx}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("after_mid_reset", {9'd0, observe()}, 32'd0);
    idle_wait(-1);
    attempt_ok($urandom_range(0, DHT - 1), rnd8(), rnd8(), LCD);
    tx_phase($urandom_range(1, TXTO), 1'b0, -1, -1);
    run_q();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_poll_scheduler.md
Name: sensor_poll_scheduler

Overview:
Sequences one cold-storage measurement cycle on the 1 MHz domain. It starts the DHT11 reader periodically or on demand, enforces a read timeout with a retry gap, and latches a valid sample. It then triggers the LCD refresh and the UART telemetry transmit in order. It sits between the DHT11 reader, the LCD driver, the UART string block and the threshold logic, and owns all start/enable timing for them.

Parameters:
POLL_PERIOD_CYC, 2000000, cycles from end of one cycle to start of next automatic poll
DHT_TIMEOUT_CYC, 50000, cycles to wait for dht_data_ready before the attempt fails
RETRY_GAP_CYC, 1000000, idle cycles between failed attempt and retry (DHT11 minimum spacing)
MAX_RETRY, 3, failed attempts allowed before declaring fault
LCD_PULSE_CYC, 4, cycles lcd_en is held high per refresh
TX_TIMEOUT_CYC, 200000, cycles to wait for tx_msg_done before abandoning transmit

Ports:
clk  in  1  1 MHz system clock
rst_n  in  1  asynchronous active-low reset
poll_now  in  1  one-cycle request for an immediate poll (UART command decode)
dht_data_ready  in  1  reader has a valid frame; sampled while dht_en=1
temperature_in  in  8  reader temperature, valid with dht_data_ready
humidity_in  in  8  reader humidity, valid with dht_data_ready
tx_msg_done  in  1  one-cycle pulse, UART message sent
dht_en  out  1  held high during a read attempt
temperature  out  8  latched last good temperature
humidity  out  8  latched last good humidity
data_valid  out  1  at least one good sample latched since reset
sensor_fault  out  1  MAX_RETRY consecutive attempts failed
lcd_en  out  1  LCD refresh strobe
en_tx  out  1  held high until tx_msg_done or timeout
tx_err  out  1  one-cycle pulse on transmit timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Clock clk; reset rst_n is asynchronous and active-low. Reset forces all outputs to 0, state to IDLE, clears counters and the pending flag, and reloads the period counter. Reset mid-operation aborts immediately; the first automatic poll occurs POLL_PERIOD_CYC cycles after reset release.
- The single down-counter has width $clog2 of the largest cycle parameter plus 1. The retry counter has width $clog2(MAX_RETRY+1).
- IDLE: counter decrements. At 0, or pending set, or poll_now: go to READ next cycle, clear pending, zero the retry count, load DHT_TIMEOUT_CYC.
- READ: dht_en=1. dht_data_ready goes to LATCH; this wins over a timeout expiring in the same cycle. On timeout, dht_en drops and the retry count increments. If the count is below MAX_RETRY, go to GAP and load RETRY_GAP_CYC; otherwise set sensor_fault and go to IDLE, reloading POLL_PERIOD_CYC, with no LCD/TX this cycle.
- GAP: dht_en=0. At counter 0, go to READ and reload the timeout.
- LATCH, one cycle: capture temperature_in and humidity_in into the output registers. Set data_valid=1, clear sensor_fault, load LCD_PULSE_CYC, go to LCD.
- LCD: lcd_en=1 for exactly LCD_PULSE_CYC cycles, then go to TX and load TX_TIMEOUT_CYC.
- TX: en_tx=1 from entry until the cycle tx_msg_done is seen, after which en_tx=0. A tx_msg_done pulse arriving outside TX is ignored. On timeout, pulse tx_err for one cycle and drop en_tx. Either exit goes to IDLE and reloads POLL_PERIOD_CYC.
- Latency: poll_now in IDLE at cycle n gives dht_en=1 at n+1. dht_data_ready at cycle m gives updated outputs at m+1 and lcd_en high for m+2 through m+1+LCD_PULSE_CYC.
- poll_now outside IDLE sets a one-deep pending flag; repeated requests coalesce. The pending poll starts on the first IDLE cycle.
- Latched temperature and humidity hold their values through failed attempts and fault; they change only in LATCH.

Test Plan:
POLL_PERIOD_CYC=1000, DHT_TIMEOUT_CYC=100, RETRY_GAP_CYC=50, LCD_PULSE_CYC=4, TX_TIMEOUT_CYC=200 used throughout.
1. Reset release, dht_data_ready at cycle 20 of READ with T=0x21, H=0x28 -> dht_en rises at cycle 1000; outputs 0x21/0x28 and data_valid=1 one cycle after ready; lcd_en high exactly 4 cycles; en_tx held until tx_msg_done at TX+30, then IDLE.
2. poll_now in IDLE -> dht_en=1 next cycle. poll_now twice during TX -> exactly one extra READ immediately after TX exits.
3. dht_data_ready never asserted -> 3 READ windows of 100 cycles separated by 50-cycle GAPs; sensor_fault=1 and no lcd_en/en_tx. A successful next poll clears sensor_fault.
4. dht_data_ready in the same cycle the timeout expires -> LATCH taken, retry count unchanged.
5. tx_msg_done withheld -> en_tx drops and tx_err pulses once after 200 cycles; the next automatic poll occurs 1000 cycles later.
6. rst_n asserted while in LCD -> lcd_en, dht_en and en_tx are 0 asynchronously. data_valid=0 and the temperature/humidity outputs are 0 after release.
